// File: rtl/ram_pipeline_bridge_n.sv
// RAM-to-butterfly operand bridge with configurable latency, hold, busy count and
// sticky protocol-error flag. Outputs are taken only from registers.
module ram_pipeline_bridge_n #(
  parameter int FFT_N    = 10,
  parameter int FFT_DW   = 16,
  parameter int PIPE_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iact,
  input  logic [1:0]            ictrl,
  input  logic                  ihold,
  input  logic [FFT_N-2:0]      iMemAddr,
  input  logic [2*FFT_DW-1:0]   iEvenData,
  input  logic [2*FFT_DW-1:0]   iOddData,
  output logic                  oact,
  output logic [1:0]            octrl,
  output logic [FFT_N-2:0]      oMemAddr,
  output logic [2*FFT_DW-1:0]   oEvenData,
  output logic [2*FFT_DW-1:0]   oOddData,
  output logic                  obusy,
  output logic                  oerr
);

  localparam int L  = PIPE_LAT + 1;
  localparam int AW = FFT_N - 1;
  localparam int DW = 2 * FFT_DW;
  localparam int CW = $clog2(L + 1);

  // act and odd data keep one extra older entry for the mode-11 partner
  logic          act_q  [1:L+1];
  logic          act_d  [1:L+1];
  logic [1:0]    ctrl_q [1:L];
  logic [1:0]    ctrl_d [1:L];
  logic [AW-1:0] addr_q [1:L];
  logic [AW-1:0] addr_d [1:L];
  logic [DW-1:0] ev_q   [1:L];
  logic [DW-1:0] ev_d   [1:L];
  logic [DW-1:0] od_q   [1:L+1];
  logic [DW-1:0] od_d   [1:L+1];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          adv;
  logic          miss_partner;

  assign adv = ~ihold;

  always_comb begin
    act_d  = act_q;
    ctrl_d = ctrl_q;
    addr_d = addr_q;
    ev_d   = ev_q;
    od_d   = od_q;
    cnt_d  = cnt_q;
    if (adv) begin
      act_d[1]  = iact;
      ctrl_d[1] = ictrl;
      addr_d[1] = iMemAddr;
      ev_d[1]   = iEvenData;
      od_d[1]   = iOddData;
      for (int k = 2; k <= L; k++) begin
        act_d[k]  = act_q[k-1];
        ctrl_d[k] = ctrl_q[k-1];
        addr_d[k] = addr_q[k-1];
        ev_d[k]   = ev_q[k-1];
      end
      for (int k = 2; k <= L + 1; k++) begin
        od_d[k] = od_q[k-1];
      end
      act_d[L+1] = act_q[L];
      cnt_d = cnt_q + CW'(iact) - CW'(act_q[L]);
    end
  end

  // a paired mode at the output needs its neighbour sample to be valid
  always_comb begin
    miss_partner = 1'b0;
    if (act_q[L]) begin
      if (ctrl_q[L] == 2'b00 && !act_q[L-1]) miss_partner = 1'b1;
      if (ctrl_q[L] == 2'b11 && !act_q[L+1]) miss_partner = 1'b1;
    end
    err_d = err_q | (iact & ihold) | (adv & miss_partner);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      act_q  <= '{default: 1'b0};
      ctrl_q <= '{default: 2'b00};
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    ev_q   <= ev_d;
    od_q   <= od_d;
  end

  assign oact     = act_q[L];
  assign octrl    = ctrl_q[L];
  assign oMemAddr = addr_q[L];
  assign obusy    = (cnt_q != '0);
  assign oerr     = err_q;

  always_comb begin
    oEvenData = ev_q[L];
    oOddData  = od_q[L];
    case (ctrl_q[L])
      2'b00: begin
        oEvenData = ev_q[L];
        oOddData  = ev_q[L-1];
      end
      2'b11: begin
        oEvenData = od_q[L+1];
        oOddData  = od_q[L];
      end
      2'b01: begin
        oEvenData = od_q[L];
        oOddData  = ev_q[L];
      end
      default: begin
        oEvenData = ev_q[L];
        oOddData  = od_q[L];
      end
    endcase
  end

endmodule

// File: tb/tb_ram_pipeline_bridge_n.sv
// Bench for ram_pipeline_bridge_n: three latencies driven by one stimulus stream,
// a sample-history model checked every cycle, plus hand-computed literal checks.
module tb_ram_pipeline_bridge_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        iact;
  logic [1:0]  ictrl;
  logic        ihold;
  logic [8:0]  iaddr;
  logic [31:0] iev, iod;

  logic        o_act  [3];
  logic [1:0]  o_ctrl [3];
  logic [8:0]  o_addr [3];
  logic [31:0] o_ev   [3];
  logic [31:0] o_od   [3];
  logic        o_busy [3];
  logic        o_err  [3];

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_pipeline_bridge_n #(.FFT_N(10), .FFT_DW(16), .PIPE_LAT(1)) u1 (
    .clk(clk), .rst(rst), .iact(iact), .ictrl(ictrl), .ihold(ihold),
    .iMemAddr(iaddr), .iEvenData(iev), .iOddData(iod),
    .oact(o_act[0]), .octrl(o_ctrl[0]), .oMemAddr(o_addr[0]),
    .oEvenData(o_ev[0]), .oOddData(o_od[0]), .obusy(o_busy[0]), .oerr(o_err[0]));

  ram_pipeline_bridge_n #(.FFT_N(10), .FFT_DW(16), .PIPE_LAT(3)) u3 (
    .clk(clk), .rst(rst), .iact(iact), .ictrl(ictrl), .ihold(ihold),
    .iMemAddr(iaddr), .iEvenData(iev), .iOddData(iod),
    .oact(o_act[1]), .octrl(o_ctrl[1]), .oMemAddr(o_addr[1]),
    .oEvenData(o_ev[1]), .oOddData(o_od[1]), .obusy(o_busy[1]), .oerr(o_err[1]));

  ram_pipeline_bridge_n #(.FFT_N(10), .FFT_DW(16), .PIPE_LAT(2)) u2 (
    .clk(clk), .rst(rst), .iact(iact), .ictrl(ictrl), .ihold(ihold),
    .iMemAddr(iaddr), .iEvenData(iev), .iOddData(iod),
    .oact(o_act[2]), .octrl(o_ctrl[2]), .oMemAddr(o_addr[2]),
    .oEvenData(o_ev[2]), .oOddData(o_od[2]), .obusy(o_busy[2]), .oerr(o_err[2]));

  function automatic int lat(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 3;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sample history indexed by age in advancing cycles (index 1 = newest).
  logic        m_act  [3][0:5];
  logic [1:0]  m_ctrl [3][0:5];
  logic [8:0]  m_addr [3][0:5];
  logic [31:0] m_ev   [3][0:5];
  logic [31:0] m_od   [3][0:5];
  logic        merr   [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        for (int k = 0; k < 6; k++) begin
          m_act[i][k]  <= 1'b0;
          m_ctrl[i][k] <= 2'b00;
        end
        merr[i] <= 1'b0;
      end else begin
        if (iact && ihold) merr[i] <= 1'b1;
        if (!ihold) begin
          if (m_act[i][lat(i)] &&
              ((m_ctrl[i][lat(i)] == 2'b00 && !m_act[i][lat(i)-1]) ||
               (m_ctrl[i][lat(i)] == 2'b11 && !m_act[i][lat(i)+1])))
            merr[i] <= 1'b1;
          for (int k = 5; k >= 2; k--) begin
            m_act[i][k]  <= m_act[i][k-1];
            m_ctrl[i][k] <= m_ctrl[i][k-1];
            m_addr[i][k] <= m_addr[i][k-1];
            m_ev[i][k]   <= m_ev[i][k-1];
            m_od[i][k]   <= m_od[i][k-1];
          end
          m_act[i][1]  <= iact;
          m_ctrl[i][1] <= ictrl;
          m_addr[i][1] <= iaddr;
          m_ev[i][1]   <= iev;
          m_od[i][1]   <= iod;
        end
      end
    end
  end

  function automatic int mcount(input int i);
    int n = 0;
    for (int k = 1; k <= lat(i); k++) if (m_act[i][k] === 1'b1) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        int l;
        logic [31:0] ea, eb;
        l = lat(i);
        cmp($sformatf("m%0d_oact", i), 64'(o_act[i]), 64'(m_act[i][l]));
        cmp($sformatf("m%0d_octrl", i), 64'(o_ctrl[i]), 64'(m_ctrl[i][l]));
        cmp($sformatf("m%0d_obusy", i), 64'(o_busy[i]), 64'(mcount(i) != 0));
        cmp($sformatf("m%0d_oerr", i), 64'(o_err[i]), 64'(merr[i]));
        if (m_act[i][l] === 1'b1) begin
          cmp($sformatf("m%0d_addr", i), 64'(o_addr[i]), 64'(m_addr[i][l]));
          case (m_ctrl[i][l])
            2'b00:   begin ea = m_ev[i][l];   eb = m_ev[i][l-1]; end
            2'b11:   begin ea = m_od[i][l+1]; eb = m_od[i][l];   end
            2'b01:   begin ea = m_od[i][l];   eb = m_ev[i][l];   end
            default: begin ea = m_ev[i][l];   eb = m_od[i][l];   end
          endcase
          if (!$isunknown(ea)) cmp($sformatf("m%0d_opA", i), 64'(o_ev[i]), 64'(ea));
          if (!$isunknown(eb)) cmp($sformatf("m%0d_opB", i), 64'(o_od[i]), 64'(eb));
        end
      end
      cmp("u1_cnt", 64'(u1.cnt_q), 64'(mcount(0)));
      cmp("u3_cnt", 64'(u3.cnt_q), 64'(mcount(1)));
      cmp("u2_cnt", 64'(u2.cnt_q), 64'(mcount(2)));
    end
  end

  task automatic drive(input logic a, input logic [1:0] c, input logic [8:0] ad,
                       input logic [31:0] e, input logic [31:0] o, input logic h);
    iact = a; ictrl = c; iaddr = ad; iev = e; iod = o; ihold = h;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 9'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    cmp("rst_oerr", 64'(o_err[0]), 64'(0));
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 2'b00, 9'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmp("reset_oact", 64'(o_act[i]), 64'(0));
      cmp("reset_octrl", 64'(o_ctrl[i]), 64'(0));
      cmp("reset_obusy", 64'(o_busy[i]), 64'(0));
      cmp("reset_oerr", 64'(o_err[i]), 64'(0));
    end
    rst = 1'b1;

    // 1: straight mode, latency 2
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cmp("t1_oact", 64'(o_act[0]), 64'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        cmp("t1_addr", 64'(o_addr[0]), 64'(c - 2));
        cmp("t1_even", 64'(o_ev[0]), 64'(32'h1000 + c - 2));
        cmp("t1_odd", 64'(o_od[0]), 64'(32'h2000 + c - 2));
      end
      cmp("t1_obusy", 64'(o_busy[0]), 64'(c >= 1 && c <= 5));
      cmp("t1_oerr", 64'(o_err[0]), 64'(0));
      if (c < 4) drive(1'b1, 2'b10, 9'(c), 32'h1000 + c, 32'h2000 + c, 1'b0);
      else       drive(1'b0, 2'b10, 9'h0, 32'h0, 32'h0, 1'b0);
    end

    // 2: alternating 00/11, latency 4
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 3) cmp("t2_lat", 64'(o_act[1]), 64'(0));
      if (c == 4) begin
        cmp("t2_oact", 64'(o_act[1]), 64'(1));
        cmp("t2_ctrl00", 64'(o_ctrl[1]), 64'(2'b00));
        cmp("t2_00_A", 64'(o_ev[1]), 64'(32'h3000_0000));
        cmp("t2_00_B", 64'(o_od[1]), 64'(32'h3000_0001));
      end
      if (c == 5) begin
        cmp("t2_ctrl11", 64'(o_ctrl[1]), 64'(2'b11));
        cmp("t2_11_A", 64'(o_ev[1]), 64'(32'h4000_0000));
        cmp("t2_11_B", 64'(o_od[1]), 64'(32'h4000_0001));
      end
      if (c == 12) cmp("t2_tail", 64'(o_act[1]), 64'(0));
      if (c == 13) cmp("t2_oerr", 64'(o_err[1]), 64'(0));
      if (c < 8) drive(1'b1, (c % 2 == 1) ? 2'b11 : 2'b00, 9'(16 + c),
                       32'h3000_0000 + c, 32'h4000_0000 + c, 1'b0);
      else       drive(1'b0, 2'b00, 9'h0, 32'h0, 32'h0, 1'b0);
    end

    // 3: swap mode
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        cmp("t3_oact", 64'(o_act[0]), 64'(1));
        cmp("t3_A", 64'(o_ev[0]), 64'(32'h1234_5678));
        cmp("t3_B", 64'(o_od[0]), 64'(32'hAAAA_5555));
      end
      if (c == 3) cmp("t3_pulse", 64'(o_act[0]), 64'(0));
      if (c == 0) drive(1'b1, 2'b01, 9'h33, 32'hAAAA_5555, 32'h1234_5678, 1'b0);
      else        drive(1'b0, 2'b00, 9'h0, 32'h0, 32'h0, 1'b0);
    end

    // 4: hold for three cycles mid-stream
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        cmp("t4_hold_act", 64'(o_act[0]), 64'(1));
        cmp("t4_hold_addr", 64'(o_addr[0]), 64'(9'h41));
        cmp("t4_hold_even", 64'(o_ev[0]), 64'(32'h5001));
        cmp("t4_hold_cnt", 64'(u1.cnt_q), 64'(2));
      end
      if (c == 7)  cmp("t4_addr7", 64'(o_addr[0]), 64'(9'h42));
      if (c == 10) cmp("t4_addr10", 64'(o_addr[0]), 64'(9'h45));
      if (c == 11) cmp("t4_end", 64'(o_act[0]), 64'(0));
      if (c < 3)       drive(1'b1, 2'b10, 9'(9'h40 + c), 32'h5000 + c, 32'h6000 + c, 1'b0);
      else if (c < 6)  drive(1'b0, 2'b10, 9'h0, 32'h0, 32'h0, 1'b1);
      else if (c < 9)  drive(1'b1, 2'b10, 9'(9'h40 + c - 3), 32'h5000 + c - 3, 32'h6000 + c - 3, 1'b0);
      else             drive(1'b0, 2'b10, 9'h0, 32'h0, 32'h0, 1'b0);
    end

    // 5a: valid sample offered during hold
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        cmp("t5a_oerr", 64'(o_err[0]), 64'(1));
        cmp("t5a_dropped", 64'(o_act[0]), 64'(0));
      end
      if (c == 0) drive(1'b1, 2'b10, 9'h55, 32'hDEAD, 32'hBEEF, 1'b1);
      else        drive(1'b0, 2'b10, 9'h0, 32'h0, 32'h0, 1'b0);
    end
    cmp("t5a_sticky_u3", 64'(o_err[1]), 64'(1));
    do_reset();

    // 5b: isolated mode-11 sample
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) begin
        cmp("t5b_oact", 64'(o_act[0]), 64'(1));
        cmp("t5b_octrl", 64'(o_ctrl[0]), 64'(2'b11));
        cmp("t5b_before", 64'(o_err[0]), 64'(0));
      end
      if (c >= 3) cmp("t5b_oerr", 64'(o_err[0]), 64'(1));
      if (c == 0) drive(1'b1, 2'b11, 9'h66, 32'h7000, 32'h8000, 1'b0);
      else        drive(1'b0, 2'b00, 9'h0, 32'h0, 32'h0, 1'b0);
    end
    do_reset();

    // 6: reset with three samples in flight, latency 3
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        cmp("t6_inflight", 64'(u2.cnt_q), 64'(3));
        cmp("t6_old_addr", 64'(o_addr[2]), 64'(9'h10));
      end
      if (c == 4) begin
        cmp("t6_oact", 64'(o_act[2]), 64'(0));
        cmp("t6_octrl", 64'(o_ctrl[2]), 64'(0));
        cmp("t6_obusy", 64'(o_busy[2]), 64'(0));
        cmp("t6_oerr", 64'(o_err[2]), 64'(0));
        rst = 1'b1;
      end
      if (c == 5 || c == 6) cmp("t6_residue", 64'(o_act[2]), 64'(0));
      if (c == 7) begin
        cmp("t6_new_act", 64'(o_act[2]), 64'(1));
        cmp("t6_new_addr", 64'(o_addr[2]), 64'(9'h100));
        cmp("t6_new_even", 64'(o_ev[2]), 64'(32'hB000));
      end
      if (c == 8) cmp("t6_new_addr2", 64'(o_addr[2]), 64'(9'h101));
      if (c == 9) cmp("t6_new_end", 64'(o_act[2]), 64'(0));
      if (c < 3) drive(1'b1, 2'b10, 9'(9'h10 + c), 32'h9000 + c, 32'hA000 + c, 1'b0);
      else if (c == 3) begin
        rst = 1'b0;
        drive(1'b1, 2'b11, 9'h1F, 32'hFFFF, 32'hEEEE, 1'b0);
      end
      else if (c < 6) drive(1'b1, 2'b10, 9'(9'h100 + c - 4), 32'hB000 + c - 4, 32'hC000 + c - 4, 1'b0);
      else            drive(1'b0, 2'b10, 9'h0, 32'h0, 32'h0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
